// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 program-counter controller: pc_src
// encodings, controller state encodings and the instruction step sizes.
package msrv32_pkg;

    localparam logic [1:0] PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] PC_SRC_NEXT = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10
    } pc_state_t;

    localparam logic [2:0] INC_4 = 3'd4;
    localparam logic [2:0] INC_2 = 3'd2;

    // Step size: 2 only for a compressed instruction on a core that allows
    // 2-byte alignment, 4 otherwise.
    function automatic logic [2:0] pc_inc(input logic align_c, input logic compressed);
        logic [2:0] inc;
        if (align_c && compressed) begin
            inc = INC_2;
        end else begin
            inc = INC_4;
        end
        return inc;
    endfunction

endpackage

// File: rtl/msrv32_pc_target_mux.sv
// Combinational next-target logic: step size, sequential address, branch
// target, misalignment detection and the pc_src selection.
import msrv32_pkg::*;

module msrv32_pc_target_mux #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   BOOT_ADDRESS = 32'h00000000,
    parameter bit                ALIGN_C      = 1'b0
) (
    input  logic [XLEN-1:0] iaddr,
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic            branch_taken,
    input  logic [XLEN-2:0] branch_addr,
    input  logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] trap_address,
    input  logic            instr_compressed,
    output logic [XLEN-1:0] seq,
    output logic [XLEN-1:0] pc_plus_inc,
    output logic [XLEN-1:0] pc_mux,
    output logic            misaligned,
    output logic            redirect
);

    logic [XLEN-1:0] inc_ext;
    logic [XLEN-1:0] branch_target;
    logic            take_branch;

    // Step, sequential address and branch target; a misaligned taken branch
    // falls back to sequential and lets the trap unit redirect later.
    always_comb begin
        inc_ext       = {{(XLEN-3){1'b0}}, pc_inc(ALIGN_C, instr_compressed)};
        seq           = iaddr + inc_ext;
        pc_plus_inc   = pc + inc_ext;
        branch_target = {branch_addr, 1'b0};
        misaligned    = branch_taken & branch_target[1] & (ALIGN_C == 1'b0);
        take_branch   = branch_taken & ~misaligned;
    end

    // Next-target selection and redirect classification.
    always_comb begin
        pc_mux   = seq;
        redirect = 1'b0;
        case (pc_src)
            PC_SRC_BOOT: begin
                pc_mux   = BOOT_ADDRESS;
                redirect = 1'b1;
            end
            PC_SRC_EPC: begin
                pc_mux   = epc;
                redirect = 1'b1;
            end
            PC_SRC_TRAP: begin
                pc_mux   = trap_address;
                redirect = 1'b1;
            end
            PC_SRC_NEXT: begin
                if (take_branch) begin
                    pc_mux   = branch_target;
                    redirect = 1'b1;
                end else begin
                    pc_mux   = seq;
                    redirect = 1'b0;
                end
            end
            default: begin
                pc_mux   = seq;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/msrv32_pc_ctrl.sv
// Registered program-counter controller: holds the fetch address stable
// while the instruction bus stalls and buffers any redirect that arrives
// during the stall so it is applied once the bus accepts again.
import msrv32_pkg::*;

module msrv32_pc_ctrl #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   BOOT_ADDRESS = 32'h00000000,
    parameter bit                ALIGN_C      = 1'b0
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic [1:0]      pc_src_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-2:0] iaddr_in,
    input  logic [XLEN-1:0] epc_in,
    input  logic [XLEN-1:0] trap_address_in,
    input  logic            instr_compressed_in,
    input  logic            ahb_ready_in,
    output logic [XLEN-1:0] ms_riscv32_mp_iaddr_out,
    output logic            imem_req_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic [XLEN-1:0] pc_mux_out,
    output logic            misaligned_instr_logic_out,
    output logic            redirect_pending_out
);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] iaddr, iaddr_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] pend_tgt, pend_tgt_nxt;
    logic            pend, pend_nxt;
    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] pc_mux;
    logic            redirect;

    msrv32_pc_target_mux #(
        .XLEN         (XLEN),
        .BOOT_ADDRESS (BOOT_ADDRESS),
        .ALIGN_C      (ALIGN_C)
    ) u_target_mux (
        .iaddr            (iaddr),
        .pc               (pc),
        .pc_src           (pc_src_in),
        .branch_taken     (branch_taken_in),
        .branch_addr      (iaddr_in),
        .epc              (epc_in),
        .trap_address     (trap_address_in),
        .instr_compressed (instr_compressed_in),
        .seq              (seq),
        .pc_plus_inc      (pc_plus_4_out),
        .pc_mux           (pc_mux),
        .misaligned       (misaligned_instr_logic_out),
        .redirect         (redirect)
    );

    // State and datapath registers; reset restarts fetching at the boot address.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state    <= ST_BOOT;
            iaddr    <= BOOT_ADDRESS;
            pc       <= BOOT_ADDRESS;
            pend     <= 1'b0;
            pend_tgt <= {XLEN{1'b0}};
        end else begin
            state    <= state_nxt;
            iaddr    <= iaddr_nxt;
            pc       <= pc_nxt;
            pend     <= pend_nxt;
            pend_tgt <= pend_tgt_nxt;
        end
    end

    // Next-state and next-address logic; everything holds unless the bus accepts.
    always_comb begin
        state_nxt    = state;
        iaddr_nxt    = iaddr;
        pc_nxt       = pc;
        pend_nxt     = pend;
        pend_tgt_nxt = pend_tgt;
        case (state)
            ST_BOOT: begin
                if (ahb_ready_in) begin
                    pc_nxt    = iaddr;
                    iaddr_nxt = seq;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_BOOT;
                end
            end
            ST_RUN: begin
                if (ahb_ready_in) begin
                    pc_nxt    = iaddr;
                    iaddr_nxt = pc_mux;
                    state_nxt = ST_RUN;
                end else begin
                    if (redirect) begin
                        pend_nxt     = 1'b1;
                        pend_tgt_nxt = pc_mux;
                    end else begin
                        pend_nxt     = pend;
                    end
                    state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (ahb_ready_in) begin
                    pc_nxt = iaddr;
                    if (redirect) begin
                        iaddr_nxt = pc_mux;
                    end else if (pend) begin
                        iaddr_nxt = pend_tgt;
                    end else begin
                        iaddr_nxt = seq;
                    end
                    pend_nxt  = 1'b0;
                    state_nxt = ST_RUN;
                end else begin
                    // Latest redirect seen during the stall wins.
                    if (redirect) begin
                        pend_nxt     = 1'b1;
                        pend_tgt_nxt = pc_mux;
                    end else begin
                        pend_nxt     = pend;
                    end
                    state_nxt = ST_STALL;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    assign ms_riscv32_mp_iaddr_out = iaddr;
    assign pc_out                  = pc;
    assign pc_mux_out              = pc_mux;
    assign redirect_pending_out    = pend;
    assign imem_req_out            = 1'b1;

endmodule

// File: doc/msrv32_pc_ctrl.md
Name: msrv32_pc_ctrl

Overview:
Registered, parametrised program-counter controller for the msrv32 core. It replaces the combinational PC mux with a clocked fetch-address register. It adds optional 16-bit (compressed) instruction stepping and a boot-fetch state. It also adds a pending-redirect buffer, so that branch, trap and epc redirects arriving while the instruction bus is stalled are never lost. It sits between the decode/branch unit, the trap/CSR unit and the AHB instruction-fetch port.

Parameters:
XLEN, 32, address width in bits (≥16).
BOOT_ADDRESS, 32'h00000000, reset fetch address (XLEN bits).
ALIGN_C, 0, 1 = 2-byte instruction alignment and compressed stepping allowed; 0 = 4-byte only.

Ports:
ms_riscv32_mp_clk_in  in  1  core clock, rising edge.
ms_riscv32_mp_rst_in  in  1  asynchronous, active-high reset.
pc_src_in  in  2  00 boot, 01 epc, 10 trap, 11 sequential/branch.
branch_taken_in  in  1  branch/jump taken this cycle.
iaddr_in  in  XLEN-1  branch target bits [XLEN-1:1]; bit 0 is implied 0.
epc_in  in  XLEN  exception return address.
trap_address_in  in  XLEN  trap vector address.
instr_compressed_in  in  1  current instruction is 16-bit; ignored when ALIGN_C=0.
ahb_ready_in  in  1  instruction bus accepts the address this cycle.
ms_riscv32_mp_iaddr_out  out  XLEN  registered fetch address.
imem_req_out  out  1  fetch request valid.
pc_out  out  XLEN  registered address of the last accepted fetch.
pc_plus_4_out  out  XLEN  sequential next address (pc_out + increment), combinational.
pc_mux_out  out  XLEN  selected next target, combinational.
misaligned_instr_logic_out  out  1  taken branch target is misaligned, combinational.
redirect_pending_out  out  1  a buffered redirect is waiting.

Behaviour:
- Reset (async, any time, including mid-stall):
  - iaddr = BOOT_ADDRESS, pc_out = BOOT_ADDRESS.
  - pending flag = 0, pending target = 0.
  - state = BOOT, imem_req_out = 1.
- Increment inc = 2 when ALIGN_C=1 and instr_compressed_in=1; otherwise 4.
- Sequential next: seq = iaddr + inc, modulo 2^XLEN. All-ones minus 3 wraps to 0; no flag is raised on wrap.
- Branch target: bt = {iaddr_in, 1'b0}.
- Misalignment: misaligned_instr_logic_out = branch_taken_in & bt[1] & (ALIGN_C==0). When asserted, bt is not used; seq is selected instead. The trap unit responds with pc_src_in=10 on a later cycle.
- Next-target mux:
  - 00 → BOOT_ADDRESS.
  - 01 → epc_in.
  - 10 → trap_address_in.
  - 11 → bt if branch taken and aligned, else seq.
- Redirect: pc_src_in≠11, or (branch_taken_in & !misaligned).
- pc_mux_out = selected target.
- pc_plus_4_out = pc_out + inc.
- FSM, one transition per clock edge:
  - BOOT: inputs pc_src_in and branch_taken_in are ignored.
    - ahb_ready_in=1: pc_out ← iaddr; iaddr ← seq; → RUN.
    - ahb_ready_in=0: hold.
  - RUN, ahb_ready_in=1: pc_out ← iaddr; iaddr ← pc_mux; stay RUN.
  - RUN, ahb_ready_in=0: iaddr and pc_out hold. If redirect, pending ← pc_mux and flag ← 1. → STALL.
  - STALL, ahb_ready_in=0: hold. A new redirect overwrites the pending target (latest wins).
  - STALL, ahb_ready_in=1:
    - pc_out ← iaddr.
    - Priority for the next iaddr: a same-cycle redirect first, then the pending target, then seq.
    - flag ← 0; → RUN.
- imem_req_out = 1 in every state after reset; the address is stable while ahb_ready_in=0.
- redirect_pending_out = pending flag (registered).
- Latency: a redirect presented with ahb_ready_in=1 appears on ms_riscv32_mp_iaddr_out the next cycle. A buffered redirect appears one cycle after ahb_ready_in returns high.

Decomposition:
- Shared package msrv32_pkg holds:
  - PC_SRC_BOOT/EPC/TRAP/NEXT 2-bit constants.
  - FSM state encodings ST_BOOT/ST_RUN/ST_STALL.
  - INC_4/INC_2 constants.
- One natural sub-module: msrv32_pc_target_mux. It is combinational and contains the increment, branch target, misalignment and next-target mux. The parent keeps the FSM and registers.

Test Plan:
- Reset release; ready=1; pc_src=11; no branch → iaddr sequence 0x0, 0x4, 0x8. pc_out lags iaddr by one cycle.
- RUN at iaddr 0x100; branch_taken=1, iaddr_in=0x40 (target 0x80); ready=1 → next iaddr 0x80. Same with target 0x82 and ALIGN_C=0 → misaligned=1, iaddr 0x104.
- Ready=0 at iaddr 0x200 with pc_src=10, trap=0x1000 → pending=1 and iaddr held at 0x200 for 3 cycles. Ready=1 → iaddr 0x1000, pending=0.
- During a stall, epc 0x300 is buffered, then trap 0x1000 arrives → on resume iaddr 0x1000 (latest wins).
- ALIGN_C=1; compressed=1 at 0x10 → 0x12; branch target 0x22 → accepted, misaligned=0.
- Reset asserted mid-STALL with pending=1 → iaddr 0x0, pending 0, state BOOT, all asynchronously. Iaddr 0xFFFFFFFC, ready=1, sequential → 0x0.
